// File: rtl/control_pkg.sv
// control_pkg: state encodings, opcode constants and error codes shared by the multicycle controller.
package control_pkg;
   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_REGLOAD  = 4'd2,
      S_ALU      = 4'd3,
      S_LOAD     = 4'd4,
      S_STORE    = 4'd5,
      S_REGSTORE = 4'd6,
      S_BRANCH   = 4'd7,
      S_NEXT     = 4'd8,
      S_HALT     = 4'd9
   } state_t;
   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LUI   = 4'd2;
   localparam logic [3:0] OP_LI    = 4'd3;
   localparam logic [3:0] OP_MV    = 4'd4;
   localparam logic [3:0] OP_BEQ   = 4'd5;
   localparam logic [3:0] OP_BNE   = 4'd6;
   localparam logic [3:0] OP_HALT  = 4'd7;
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: datapath/controller handshake; master is the controller side.
interface multicycle_control_if #(parameter int OPCODE_SIZE = 4);
   logic [OPCODE_SIZE-1:0] opcode;
   logic is_alu_operation;
   logic mem_ready;
   logic do_fetch, do_load, do_alu, do_mem_load, do_mem_store;
   logic do_reg_store, do_branch, do_next, do_reset, do_halt;
   logic [3:0] state;
   logic [1:0] error_code;
   modport master (
      input  opcode, is_alu_operation, mem_ready,
      output do_fetch, do_load, do_alu, do_mem_load, do_mem_store,
             do_reg_store, do_branch, do_next, do_reset, do_halt, state, error_code
   );
   modport slave (
      output opcode, is_alu_operation, mem_ready,
      input  do_fetch, do_load, do_alu, do_mem_load, do_mem_store,
             do_reg_store, do_branch, do_next, do_reset, do_halt, state, error_code
   );
endinterface

// File: rtl/wait_counter.sv
// wait_counter: clearable counter that stops at limit and flags when the limit is reached.
module wait_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         reached
);
   logic [W-1:0] count;
   always_ff @(posedge clock)
      count <= (reset || clear) ? '0 : (enable && count < limit) ? count + 1'b1 : count;
   assign reached = count >= limit;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM; MULTICYCLE_CONTROL_PERF_EN adds cycle/instruction counters.
module multicycle_control
   import control_pkg::*;
#(
   parameter int OPCODE_SIZE = 4,
   parameter int ALU_LATENCY = 1,
   parameter int MEM_TIMEOUT = 15,
   parameter int COUNT_W     = 32
) (
   input  logic clock,
   input  logic reset,
   multicycle_control_if.master bus
`ifdef MULTICYCLE_CONTROL_PERF_EN
   ,
   output logic [COUNT_W-1:0] cycle_count,
   output logic [COUNT_W-1:0] instr_count
`endif
);
   state_t state, dec_state;
   logic [1:0] error_code;
   logic illegal, alu_done, mem_limit, mem_state;
   always_comb begin
      dec_state = (bus.opcode == OPCODE_SIZE'(OP_LOAD))  ? S_LOAD :
                  (bus.opcode == OPCODE_SIZE'(OP_STORE)) ? S_STORE :
                  (bus.opcode == OPCODE_SIZE'(OP_LUI) || bus.opcode == OPCODE_SIZE'(OP_LI) ||
                   bus.opcode == OPCODE_SIZE'(OP_MV))    ? S_REGSTORE :
                  (bus.opcode == OPCODE_SIZE'(OP_BEQ) || bus.opcode == OPCODE_SIZE'(OP_BNE)) ? S_BRANCH :
                  S_HALT;
      illegal = !bus.is_alu_operation && dec_state == S_HALT && bus.opcode != OPCODE_SIZE'(OP_HALT);
   end
   assign mem_state = state == S_FETCH || state == S_LOAD || state == S_STORE;
   wait_counter #(.W(4)) alu_cnt (
      .clock(clock), .reset(reset), .clear(state != S_ALU), .enable(state == S_ALU),
      .limit(4'(ALU_LATENCY - 1)), .reached(alu_done)
   );
   // limit is one below the timeout so the final missed cycle is the one that traps
   wait_counter #(.W(8)) mem_cnt (
      .clock(clock), .reset(reset), .clear(!mem_state), .enable(mem_state && !bus.mem_ready),
      .limit(8'(MEM_TIMEOUT - 1)), .reached(mem_limit)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_RESET;
         error_code <= ERR_NONE;
      end else begin
         case (state)
            S_RESET: state <= S_FETCH;
            S_FETCH, S_LOAD, S_STORE:
               if (bus.mem_ready)
                  state <= (state == S_FETCH) ? S_REGLOAD : (state == S_LOAD) ? S_REGSTORE : S_NEXT;
               else if (mem_limit) begin
                  state      <= S_HALT;
                  error_code <= ERR_TIMEOUT;
               end
            S_REGLOAD: begin
               state <= bus.is_alu_operation ? S_ALU : dec_state;
               if (illegal) error_code <= ERR_ILLEGAL;
            end
            S_ALU: if (alu_done) state <= S_REGSTORE;
            S_REGSTORE, S_BRANCH: state <= S_NEXT;
            S_NEXT: state <= S_FETCH;
            default: state <= S_HALT;
         endcase
      end
   end
   assign bus.state        = state;
   assign bus.error_code   = error_code;
   assign bus.do_reset     = state == S_RESET;
   assign bus.do_fetch     = state == S_FETCH;
   assign bus.do_load      = state == S_REGLOAD;
   assign bus.do_alu       = state == S_ALU;
   assign bus.do_mem_load  = state == S_LOAD;
   assign bus.do_mem_store = state == S_STORE;
   assign bus.do_reg_store = state == S_REGSTORE;
   assign bus.do_branch    = state == S_BRANCH;
   assign bus.do_next      = state == S_NEXT;
   assign bus.do_halt      = state == S_HALT;
`ifdef MULTICYCLE_CONTROL_PERF_EN
   always_ff @(posedge clock) begin
      cycle_count <= reset ? '0 : (state != S_HALT) ? cycle_count + 1'b1 : cycle_count;
      instr_count <= reset ? '0 : (state == S_NEXT) ? instr_count + 1'b1 : instr_count;
   end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: builds per-instruction expected state traces and checks the controller cycle by cycle.
module tb_multicycle_control;
   import control_pkg::*;
   localparam int ALU_LAT = 3;
   localparam int MEM_TO  = 15;
   typedef struct {
      logic [3:0] st;
      logic [1:0] err;
      logic       mr;
      logic [3:0] op;
      logic       alu;
   } step_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   step_t q[$];
   logic [1:0] cur_err;
   logic [3:0] cur_op;
   logic cur_alu;
   bit halted;
   int cc, ic;
   multicycle_control_if #(.OPCODE_SIZE(4)) bus ();
`ifdef MULTICYCLE_CONTROL_PERF_EN
   logic [31:0] cycle_count, instr_count;
   multicycle_control #(.OPCODE_SIZE(4), .ALU_LATENCY(ALU_LAT), .MEM_TIMEOUT(MEM_TO), .COUNT_W(32)) dut (
      .clock(clock), .reset(reset), .bus(bus), .cycle_count(cycle_count), .instr_count(instr_count));
`else
   multicycle_control #(.OPCODE_SIZE(4), .ALU_LATENCY(ALU_LAT), .MEM_TIMEOUT(MEM_TO), .COUNT_W(32)) dut (
      .clock(clock), .reset(reset), .bus(bus));
`endif
   always #5 clock = ~clock;
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [9:0] do_vec();
      return {bus.do_halt, bus.do_next, bus.do_branch, bus.do_reg_store, bus.do_mem_store,
              bus.do_mem_load, bus.do_alu, bus.do_load, bus.do_fetch, bus.do_reset};
   endfunction
   task automatic push(input logic [3:0] st, input logic mr);
      q.push_back('{st, cur_err, mr, cur_op, cur_alu});
   endtask
   // memory phase: d cycles without mem_ready, then ready; d >= MEM_TO traps
   task automatic mem_wait(input logic [3:0] st, input int d);
      for (int i = 0; i < d && i < MEM_TO; i++) push(st, 1'b0);
      if (d >= MEM_TO) begin
         cur_err = ERR_TIMEOUT;
         push(S_HALT, 1'($urandom));
         halted = 1;
      end else push(st, 1'b1);
   endtask
   task automatic gen(input int fd, input logic [3:0] op, input logic alu, input int md);
      if (halted) return;
      cur_op = op;
      cur_alu = alu;
      mem_wait(S_FETCH, fd);
      if (halted) return;
      push(S_REGLOAD, 1'($urandom));
      if (alu) begin
         repeat (ALU_LAT) push(S_ALU, 1'($urandom));
         push(S_REGSTORE, 1'($urandom));
         push(S_NEXT, 1'($urandom));
      end else if (op == OP_LOAD) begin
         mem_wait(S_LOAD, md);
         if (!halted) begin
            push(S_REGSTORE, 1'($urandom));
            push(S_NEXT, 1'($urandom));
         end
      end else if (op == OP_STORE) begin
         mem_wait(S_STORE, md);
         if (!halted) push(S_NEXT, 1'($urandom));
      end else if (op == OP_LUI || op == OP_LI || op == OP_MV) begin
         push(S_REGSTORE, 1'($urandom));
         push(S_NEXT, 1'($urandom));
      end else if (op == OP_BEQ || op == OP_BNE) begin
         push(S_BRANCH, 1'($urandom));
         push(S_NEXT, 1'($urandom));
      end else begin
         if (op != OP_HALT) cur_err = ERR_ILLEGAL;
         push(S_HALT, 1'($urandom));
         halted = 1;
      end
   endtask
   task automatic halt_tail();
      repeat (3) push(S_HALT, 1'($urandom));
   endtask
   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clock);
      #1;
      chk("reset_state", bus.state, S_RESET);
      chk("reset_err", bus.error_code, ERR_NONE);
      chk("reset_do", do_vec(), 10'b1);
`ifdef MULTICYCLE_CONTROL_PERF_EN
      chk("reset_cycle_count", cycle_count, 0);
      chk("reset_instr_count", instr_count, 0);
`endif
      reset = 1'b0;
      cur_err = ERR_NONE;
      halted = 0;
      cc = 0;
      ic = 0;
      q.delete();
      push(S_RESET, 1'b0);
   endtask
   task automatic run(input int n);
      int lim;
      lim = (n < 0 || n > q.size()) ? q.size() : n;
      for (int i = 0; i < lim; i++) begin
         chk($sformatf("state[%0d]", i), bus.state, q[i].st);
         chk($sformatf("err[%0d]", i), bus.error_code, q[i].err);
         chk($sformatf("do[%0d]", i), do_vec(), 10'b1 << q[i].st);
`ifdef MULTICYCLE_CONTROL_PERF_EN
         chk($sformatf("cycle_count[%0d]", i), cycle_count, cc);
         chk($sformatf("instr_count[%0d]", i), instr_count, ic);
`endif
         if (q[i].st != S_HALT) cc++;
         if (q[i].st == S_NEXT) ic++;
         bus.mem_ready = q[i].mr;
         bus.opcode = q[i].op;
         bus.is_alu_operation = q[i].alu;
         @(posedge clock);
         #1;
      end
      q.delete();
   endtask
   initial begin
      bus.mem_ready = 1'b0;
      bus.opcode = 4'd0;
      bus.is_alu_operation = 1'b0;
      // ALU instruction with 3-cycle latency after a 2-cycle reset
      do_reset(2);
      gen(0, OP_LOAD, 1'b1, 0);
      push(S_FETCH, 1'b0);
      run(-1);
      // LOAD stalled 4 cycles
      do_reset(1);
      gen(0, OP_LOAD, 1'b0, 4);
      push(S_FETCH, 1'b0);
      run(-1);
      // STORE with memory never ready
      do_reset(1);
      gen(0, OP_STORE, 1'b0, 20);
      halt_tail();
      run(-1);
      // unassigned opcode, then reset clears the error
      do_reset(1);
      gen(1, 4'hC, 1'b0, 0);
      halt_tail();
      run(-1);
      do_reset(1);
      // fetch completing on the last allowed cycle, then fetch timeout
      gen(MEM_TO - 1, OP_LI, 1'b0, 0);
      gen(MEM_TO, OP_LI, 1'b0, 0);
      halt_tail();
      run(-1);
      // reset during the second ALU cycle
      do_reset(1);
      gen(0, OP_MV, 1'b1, 0);
      run(4);
      chk("mid_alu_state", bus.state, S_ALU);
      do_reset(1);
      repeat (3) gen($urandom_range(0, 3), OP_BEQ, 1'b0, 0);
      push(S_FETCH, 1'b0);
      run(-1);
`ifdef MULTICYCLE_CONTROL_PERF_EN
      chk("beq_instr_count", instr_count, 3);
`endif
      // randomized programs ending in a halt, illegal opcode or memory timeout
      for (int s = 0; s < 6; s++) begin
         int kind;
         do_reset($urandom_range(1, 2));
         repeat (10) gen($urandom_range(0, 4), 4'($urandom_range(0, 6)),
                         $urandom_range(0, 3) == 0, $urandom_range(0, MEM_TO - 1));
         kind = $urandom_range(0, 3);
         case (kind)
            0: gen(0, OP_HALT, 1'b0, 0);
            1: gen(0, 4'($urandom_range(8, 15)), 1'b0, 0);
            2: gen(0, OP_LOAD, 1'b0, MEM_TO + $urandom_range(0, 3));
            default: gen(MEM_TO, OP_LI, 1'b0, 0);
         endcase
         halt_tail();
         run(-1);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_SIZE, default 4: opcode width in bits.
REQ-002 Parameter ALU_LATENCY, default 1: cycles spent in ALU state; legal range 1..15.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum cycles to wait for mem_ready before trapping; legal range 1..255.
REQ-004 Parameter COUNT_W, default 32: performance counter width.
REQ-005 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port opcode, input, OPCODE_SIZE: decoded instruction opcode, valid in REGLOAD.
REQ-008 Port is_alu_operation, input, 1: opcode is an ALU operation.
REQ-009 Port mem_ready, input, 1: memory completes the current fetch, load or store this cycle.
REQ-010 Ports do_fetch, do_load, do_alu, do_mem_load, do_mem_store, do_reg_store, do_branch, do_next, do_reset, do_halt: each output, 1 bit, high exactly while in the matching state.
REQ-011 Port state, output, 4: current state encoding.
REQ-012 Port error_code, output, 2: 0 none, 1 illegal opcode, 2 memory timeout; sticky until reset.
REQ-013 Ports cycle_count and instr_count, output, COUNT_W: present only with the configuration macro.

Function
REQ-014 States SHALL be RESET, FETCH, REGLOAD, ALU, LOAD, STORE, REGSTORE, BRANCH, NEXT and HALT; all do_* outputs SHALL be decoded from registered state and be one-hot.
REQ-015 RESET SHALL go to FETCH.
REQ-016 FETCH SHALL go to REGLOAD on the cycle mem_ready is high; otherwise FETCH SHALL hold.
REQ-017 REGLOAD decode (is_alu_operation has priority):
- ALU operation -> ALU
- LOAD -> LOAD
- STORE -> STORE
- LUI, LI or MV -> REGSTORE
- BEQ or BNE -> BRANCH
- HALT -> HALT
- any other opcode -> HALT, with error_code set to 1.
REQ-018 ALU SHALL last exactly ALU_LATENCY cycles, then go to REGSTORE.
REQ-019 LOAD SHALL wait for mem_ready, then go to REGSTORE; STORE SHALL wait for mem_ready, then go to NEXT.
REQ-020 Memory wait counting:
- A wait counter SHALL clear on entry to FETCH, LOAD or STORE.
- It SHALL increment on each cycle in that state without mem_ready.
- If the counter reaches MEM_TIMEOUT without mem_ready, the next state SHALL be HALT with error_code set to 2.
- mem_ready high on the same cycle as the limit is reached SHALL complete normally.
REQ-021 REGSTORE and BRANCH SHALL each last one cycle, then go to NEXT.
REQ-022 NEXT SHALL last one cycle, then go to FETCH.
REQ-023 HALT SHALL be absorbing; only reset leaves it.
REQ-024 The wait counter and the ALU counter SHALL saturate and never wrap.

Reset
REQ-025 When reset is high at a clock edge, from any state (including mid-wait or mid-ALU), the following SHALL take effect on that edge:
- state = RESET and do_reset = 1
- all other do_* = 0
- error_code = 0
- internal counters = 0
- performance counters = 0.
REQ-026 While reset stays high, state SHALL remain RESET.

Configuration
REQ-027 With MULTICYCLE_CONTROL_PERF_EN defined:
- cycle_count SHALL increment every non-reset cycle while not in HALT.
- instr_count SHALL increment on each NEXT cycle.
- Both counters SHALL wrap modulo 2^COUNT_W.
REQ-028 Without MULTICYCLE_CONTROL_PERF_EN, the cycle_count and instr_count ports and their logic SHALL be absent.

Structure
REQ-029 A shared package control_pkg SHALL hold the state encodings (4-bit), opcode constants (LOAD, STORE, LUI, LI, MV, BEQ, BNE, HALT) and the error_code values.
REQ-030 One sub-module, wait_counter (clear, enable and limit inputs; saturating, with a reached-limit output), SHALL be instantiated twice: once for ALU latency and once for the memory timeout.

Verification
REQ-031 Reset for 2 cycles, then mem_ready = 1 and an ALU opcode with ALU_LATENCY = 3 -> state sequence RESET, FETCH, REGLOAD, ALU x3, REGSTORE, NEXT, FETCH.
REQ-032 LOAD with mem_ready low for 4 cycles, then high -> LOAD held 5 cycles, then REGSTORE, NEXT; error_code = 0.
REQ-033 STORE with mem_ready held low and MEM_TIMEOUT = 15 -> HALT after 15 wait cycles, error_code = 2, do_halt stays high thereafter.
REQ-034 Unassigned opcode in REGLOAD -> HALT next cycle with error_code = 1; assert reset for 1 cycle -> RESET, error_code = 0.
REQ-035 Reset asserted during the second ALU cycle -> RESET on the next edge with no REGSTORE; with the macro defined, after 3 complete BEQ instructions -> instr_count = 3.
